// File: rtl/robertson_mult_ctrl_if.sv
// Start/operand/result bundle for robertson_mult_ctrl.
// The master side issues requests; the slave side is the multiplier.
interface robertson_mult_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/robertson_mult_ctrl.sv
// Sequential signed multiplier (Robertson add/shift, one step per clock).
// Define ROBERTSON_ZERO_SKIP_EN to finish zero-operand requests in one cycle.
module robertson_mult_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    robertson_mult_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned PRD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_m;
    logic                 r_busy;
    logic                 r_done;
    logic [PRD_W-1:0]     r_product;

    logic                 w_last;
    logic                 w_cin;
    logic                 w_zero_skip;
    logic [SUM_W-1:0]     w_a_ext;
    logic [SUM_W-1:0]     w_m_ext;
    logic [SUM_W-1:0]     w_addend;
    logic [SUM_W-1:0]     w_sum;

    // The final step subtracts M because the multiplier's MSB carries negative weight.
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_a_ext  = {r_a[WIDTH-1], r_a};
    assign w_m_ext  = {r_m[WIDTH-1], r_m};
    assign w_addend = r_q[0] ? (w_last ? ~w_m_ext : w_m_ext) : '0;
    assign w_cin    = r_q[0] & w_last;
    assign w_sum    = w_a_ext + w_addend + SUM_W'(w_cin);

`ifdef ROBERTSON_ZERO_SKIP_EN
    assign w_zero_skip = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // Control FSM and datapath registers; the sum's extra bit becomes A's new MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m    <= bus.multiplicand;
                        r_q    <= bus.multiplier;
                        r_a    <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (w_zero_skip) begin
                            r_product <= '0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_sum[WIDTH:1];
                    r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product <= {w_sum[WIDTH:1], w_sum[0], r_q[WIDTH-1:1]};
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule

// File: tb/tb_robertson_mult_ctrl.sv
// Directed-vector bench for robertson_mult_ctrl (WIDTH=8): latency, products,
// ignored/held start, mid-operation reset, and the zero-operand case.
module tb_robertson_mult_ctrl;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    robertson_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

    robertson_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request at the next edge, scramble operands afterwards, and
    // measure the done cycle (cycle 1 = first cycle after the accepting edge).
    task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                          input logic [31:0] exp_p, input int exp_lat);
        int lat;
        int busy_bad;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.multiplicand = ~m;
        bus.multiplier   = q ^ 8'h5A;
        lat      = 0;
        busy_bad = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) lat = c;
        end
        check({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        check({tag, "_prod"}, 32'(bus.product), exp_p);
        @(posedge clk); #1;
        check({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({tag, "_hold"}, 32'(bus.product), exp_p);
    endtask

    initial begin
        int n_done;
        int d1;
        int d2;
        int zero_lat;
        n_checks = 0;
        n_errors = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {14'd0, bus.busy, bus.done, bus.product}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First request right after reset release, then the reference vectors.
        run_op("p3x5",      8'd3,   8'd5,   32'h000F, WIDTH + 1);
        run_op("m3x5",      8'hFD,  8'd5,   32'hFFF1, WIDTH + 1);
        run_op("p5xm3",     8'd5,   8'hFD,  32'hFFF1, WIDTH + 1);
        run_op("m128xm128", 8'h80,  8'h80,  32'h4000, WIDTH + 1);
        run_op("p127xm128", 8'h7F,  8'h80,  32'hC080, WIDTH + 1);
        run_op("m128xp127", 8'h80,  8'h7F,  32'hC080, WIDTH + 1);
        run_op("p127xp127", 8'h7F,  8'h7F,  32'h3F01, WIDTH + 1);
        run_op("m1xm1",     8'hFF,  8'hFF,  32'h0001, WIDTH + 1);
        run_op("m1xp1",     8'hFF,  8'h01,  32'hFFFF, WIDTH + 1);

`ifdef ROBERTSON_ZERO_SKIP_EN
        zero_lat = 1;
`else
        zero_lat = WIDTH + 1;
`endif
        run_op("z_m",  8'h00, 8'h55, 32'h0000, zero_lat);
        run_op("z_q",  8'h55, 8'h00, 32'h0000, zero_lat);
        run_op("nz",   8'd12, 8'hF6, 32'hFF88, WIDTH + 1);

        // Second start issued during RUN must be ignored.
        bus.multiplicand = 8'd3;
        bus.multiplier   = 8'd5;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_done = 0;
        d1     = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (c == 4) begin
                bus.multiplicand = 8'd7;
                bus.multiplier   = 8'd9;
                bus.start        = 1'b1;
            end
            if (c == 5) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                n_done++;
                if (d1 == 0) d1 = c;
            end
        end
        check("ign_count", 32'(n_done), 32'd1);
        check("ign_cycle", 32'(d1), 32'(WIDTH + 1));
        check("ign_prod",  32'(bus.product), 32'h000F);

        // Start held high relaunches after a single IDLE cycle.
        bus.multiplicand = 8'd2;
        bus.multiplier   = 8'd3;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 40 && d2 == 0; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (bus.done === 1'b1) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
        end
        bus.start = 1'b0;
        check("held_first", 32'(d1), 32'(WIDTH + 1));
        check("held_gap",   32'(d2 - d1), 32'(WIDTH + 2));
        check("held_prod",  32'(bus.product), 32'h0006);
        repeat (3) @(posedge clk);
        #1;
        check("held_stop", {30'd0, bus.busy, bus.done}, 32'd0);

        // Reset in cycle 5 of an operation clears outputs without an edge.
        bus.multiplicand = 8'd3;
        bus.multiplier   = 8'd5;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst", {14'd0, bus.busy, bus.done, bus.product}, 32'd0);
        n_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) n_done++;
        end
        check("rst_no_done", 32'(n_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 8'hF9, 8'd6, 32'hFFD6, WIDTH + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
